// File: rtl/sec_pkg.sv
// ============================================================================
// Module      : sec_pkg
// Description : Shared definitions for the pipelined SEC Hamming decoder:
//               default widths, the 136/128 H-matrix, a reference syndrome
//               function and the decode status type.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sec_pkg;

  localparam int DATA_W_DEF = 128;
  localparam int PAR_W_DEF  = 8;
  localparam int CW_W_DEF   = DATA_W_DEF + PAR_W_DEF;
  localparam int H_W_DEF    = CW_W_DEF * PAR_W_DEF;
  localparam int POS_W_DEF  = $clog2(CW_W_DEF);

  typedef enum logic [1:0] {
    ST_OK  = 2'd0,
    ST_CE  = 2'd1,
    ST_DUE = 2'd2
  } dec_status_t;

  // Bit-index width for a codeword of cw_w bits (never below 1).
  function automatic int pos_width(input int cw_w);
    return (cw_w > 1) ? $clog2(cw_w) : 1;
  endfunction

  // Builds the default H-matrix. Parity columns are unit vectors. Data
  // columns take every 8-bit value of weight >= 2 in ascending order, except
  // that the two top data columns are pinned to 8'h4A (bit 134) and 8'hAB
  // (bit 135) so their syndromes are easy to recognise on the bench; those
  // two values are skipped in the ascending fill to keep columns unique.
  function automatic logic [H_W_DEF-1:0] gen_h_136_128();
    logic [H_W_DEF-1:0] h;
    logic [7:0]         b;
    int                 k;
    h = '0;
    k = 0;
    for (int j = 0; j < PAR_W_DEF; j++) begin
      h[j*PAR_W_DEF +: PAR_W_DEF] = 8'(1 << j);
    end
    for (int v = 3; v < 256; v++) begin
      b = v[7:0];
      if ((k < DATA_W_DEF - 2) && ((b & (b - 8'd1)) != 8'd0) &&
          (b != 8'hAB) && (b != 8'h4A)) begin
        h[(PAR_W_DEF + k)*PAR_W_DEF +: PAR_W_DEF] = b;
        k++;
      end
    end
    h[134*PAR_W_DEF +: PAR_W_DEF] = 8'h4A;
    h[135*PAR_W_DEF +: PAR_W_DEF] = 8'hAB;
    return h;
  endfunction

  localparam logic [H_W_DEF-1:0] H_136_128 = gen_h_136_128();

  // Syndrome of a default-width codeword: XOR of the H columns of every set bit.
  function automatic logic [PAR_W_DEF-1:0] syndrome_calc(
    input logic [CW_W_DEF-1:0] cw,
    input logic [H_W_DEF-1:0]  h
  );
    logic [PAR_W_DEF-1:0] s;
    s = '0;
    for (int j = 0; j < CW_W_DEF; j++) begin
      if (cw[j]) s = s ^ h[j*PAR_W_DEF +: PAR_W_DEF];
    end
    return s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sec_decoder_pipe_match.sv
// ============================================================================
// Module      : sec_syndrome_match
// Description : Combinational syndrome-to-position lookup. Compares the
//               syndrome against every H column.
// Ports       : syn (in)  syndrome
//               hit (out) syndrome equals a column
//               pos (out) index of the matching column, 0 when no hit
//               due (out) non-zero syndrome without a column match
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sec_syndrome_match
  import sec_pkg::*;
#(
  parameter int                      PAR_W  = PAR_W_DEF,
  parameter int                      CW_W   = CW_W_DEF,
  parameter logic [CW_W*PAR_W-1:0]   H_COLS = H_136_128
) (
  input  logic [PAR_W-1:0]         syn,
  output logic                     hit,
  output logic [$clog2(CW_W)-1:0]  pos,
  output logic                     due
);

  localparam int POS_W = $clog2(CW_W);

  // Columns are unique, so at most one comparison can succeed.
  always_comb begin
    hit = 1'b0;
    pos = '0;
    for (int j = 0; j < CW_W; j++) begin
      if (syn == H_COLS[j*PAR_W +: PAR_W]) begin
        hit = 1'b1;
        pos = POS_W'(j);
      end
    end
    due = (syn != '0) && !hit;
  end

endmodule

`default_nettype wire

// File: rtl/sec_decoder_pipe.sv
// ============================================================================
// Module      : sec_decoder_pipe
// Description : Two-stage pipelined SEC Hamming decoder with valid/ready
//               handshake, stall-all backpressure and saturating CE/DUE
//               event counters.
//               Stage 1 registers codeword, tag and syndrome; stage 2
//               registers the corrected message and status.
// Ports       : clk, rst                 clock, synchronous active-high reset
//               in_valid/in_ready        input handshake
//               in_cw, in_tag            codeword (msg high, parity low), tag
//               out_valid/out_ready      output handshake
//               out_msg, out_tag         corrected message, tag
//               out_ce, out_due, out_pos status and corrected bit index
//               cnt_clr                  clears counters (and error log)
//               ce_cnt, due_cnt          saturating event counters
//               log_valid/log_syn/log_tag  first-DUE log, present only when
//                                        SEC_DECODER_ERR_LOG_EN is defined
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sec_decoder_pipe
  import sec_pkg::*;
#(
  parameter int                      DATA_W = 128,
  parameter int                      PAR_W  = 8,
  parameter int                      CW_W   = DATA_W + PAR_W,
  parameter logic [CW_W*PAR_W-1:0]   H_COLS = H_136_128,
  parameter int                      CNT_W  = 16,
  parameter int                      TAG_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [CW_W-1:0]          in_cw,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_msg,
  output logic [TAG_W-1:0]         out_tag,
  output logic                     out_ce,
  output logic                     out_due,
  output logic [$clog2(CW_W)-1:0]  out_pos,
  input  logic                     cnt_clr,
  output logic [CNT_W-1:0]         ce_cnt,
  output logic [CNT_W-1:0]         due_cnt
`ifdef SEC_DECODER_ERR_LOG_EN
  ,
  output logic                     log_valid,
  output logic [PAR_W-1:0]         log_syn,
  output logic [TAG_W-1:0]         log_tag
`endif
);

  localparam int              POS_W   = $clog2(CW_W);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // --------------------------------------------------------------------------
  // H-matrix sanity: no zero column, no duplicates, unit parity columns.
  // --------------------------------------------------------------------------
  function automatic bit h_cols_ok();
    logic [PAR_W-1:0] a;
    logic [PAR_W-1:0] b;
    bit               ok;
    ok = 1'b1;
    for (int j = 0; j < CW_W; j++) begin
      a = H_COLS[j*PAR_W +: PAR_W];
      if (a == '0) ok = 1'b0;
      if ((j < PAR_W) && (a != (PAR_W'(1) << j))) ok = 1'b0;
      for (int k = j + 1; k < CW_W; k++) begin
        b = H_COLS[k*PAR_W +: PAR_W];
        if (a == b) ok = 1'b0;
      end
    end
    return ok;
  endfunction

  if (!h_cols_ok()) begin : g_h_check
    $error("sec_decoder_pipe: H_COLS has a zero, duplicate or non-unit parity column");
  end

  // --------------------------------------------------------------------------
  // Handshake: the whole pipe advances together, gated only by the output.
  // --------------------------------------------------------------------------
  logic s1_valid;
  logic s2_valid;
  logic adv;

  assign adv       = !s2_valid || out_ready;
  assign in_ready  = adv;
  assign out_valid = s2_valid;

  // --------------------------------------------------------------------------
  // Stage 1: syndrome of the incoming codeword
  // --------------------------------------------------------------------------
  logic [PAR_W-1:0] syn_c;
  logic [CW_W-1:0]  s1_cw;
  logic [TAG_W-1:0] s1_tag;
  logic [PAR_W-1:0] s1_syn;

  always_comb begin
    syn_c = '0;
    for (int i = 0; i < PAR_W; i++) begin
      for (int j = 0; j < CW_W; j++) begin
        syn_c[i] = syn_c[i] ^ (in_cw[j] & H_COLS[j*PAR_W + i]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_cw    <= '0;
      s1_tag   <= '0;
      s1_syn   <= '0;
    end else if (adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_cw  <= in_cw;
        s1_tag <= in_tag;
        s1_syn <= syn_c;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stage 2: locate and correct
  // --------------------------------------------------------------------------
  logic              m_hit;
  logic              m_due;
  logic [POS_W-1:0]  m_pos;
  logic [DATA_W-1:0] corr_msg;
  dec_status_t       st_c;

  sec_syndrome_match #(
    .PAR_W  (PAR_W),
    .CW_W   (CW_W),
    .H_COLS (H_COLS)
  ) u_match (
    .syn (s1_syn),
    .hit (m_hit),
    .pos (m_pos),
    .due (m_due)
  );

  // Only data-column hits change the message; a parity-column hit leaves
  // every message bit untouched.
  always_comb begin
    corr_msg = '0;
    for (int i = 0; i < DATA_W; i++) begin
      corr_msg[i] = s1_cw[PAR_W + i] ^ (m_hit && (m_pos == POS_W'(PAR_W + i)));
    end
  end

  always_comb begin
    st_c = ST_OK;
    if (m_hit)      st_c = ST_CE;
    else if (m_due) st_c = ST_DUE;
  end

`ifdef SEC_DECODER_ERR_LOG_EN
  logic [PAR_W-1:0] s2_syn;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      out_msg  <= '0;
      out_tag  <= '0;
      out_ce   <= 1'b0;
      out_due  <= 1'b0;
      out_pos  <= '0;
`ifdef SEC_DECODER_ERR_LOG_EN
      s2_syn   <= '0;
`endif
    end else if (adv) begin
      s2_valid <= s1_valid;
      // Bubbles clear the result fields so an idle output reads all-zero.
      if (s1_valid) begin
        out_msg <= corr_msg;
        out_tag <= s1_tag;
        out_ce  <= (st_c == ST_CE);
        out_due <= (st_c == ST_DUE);
        out_pos <= m_pos;
`ifdef SEC_DECODER_ERR_LOG_EN
        s2_syn  <= s1_syn;
`endif
      end else begin
        out_msg <= '0;
        out_tag <= '0;
        out_ce  <= 1'b0;
        out_due <= 1'b0;
        out_pos <= '0;
`ifdef SEC_DECODER_ERR_LOG_EN
        s2_syn  <= '0;
`endif
      end
    end
  end

  // --------------------------------------------------------------------------
  // Event counters: count transfers, not cycles, so stalls never double-count.
  // --------------------------------------------------------------------------
  logic xfer;
  assign xfer = s2_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      ce_cnt <= '0;
    end else if (xfer && out_ce && (ce_cnt != CNT_MAX)) begin
      ce_cnt <= ce_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      due_cnt <= '0;
    end else if (xfer && out_due && (due_cnt != CNT_MAX)) begin
      due_cnt <= due_cnt + 1'b1;
    end
  end

`ifdef SEC_DECODER_ERR_LOG_EN
  // Sticky log of the first uncorrectable error since reset or clear.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      log_valid <= 1'b0;
      log_syn   <= '0;
      log_tag   <= '0;
    end else if (xfer && out_due && !log_valid) begin
      log_valid <= 1'b1;
      log_syn   <= s2_syn;
      log_tag   <= out_tag;
    end
  end
`endif

endmodule

`default_nettype wire
